multicycle_control_unit: RTL

Parametrised multi-cycle sequencer for the SC8b CPU datapath, replacing single-cycle combinational decode with an explicit FSM. Fetches over a ready/ack instruction port, decodes into a held instruction register, and steps ALU, branch, load and store through separate phases with wait-state handshakes on both memories. Adds HALT, illegal-opcode reporting and a bus-timeout error that the single-cycle control path lacks. Sits between PC/IMEM, register file, ALU/flags and DMEM.

---
 rtl/multicycle_control_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the SC8b datapath: fetch/decode/exec/mem/wb FSM
// with ready/ack memory handshakes, HALT, illegal-opcode flag and bus timeout.
module multicycle_control_unit #(
   parameter int IW      = 8,
   parameter int RA      = 2,
   parameter int TIMEOUT = 15
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic [IW-1:0] IMEM_RDATA,
   input  logic          IMEM_ACK,
   input  logic          DMEM_ACK,
   input  logic          NF,
   input  logic          OF,
   input  logic          ZF,
   output logic [IW-1:0] INST_Q,
   output logic          IMEM_REQ,
   output logic          DMEM_REQ,
   output logic          DMEM_W_EN,
   output logic          PC_EN,
   output logic          PC_LD_EN,
   output logic [RA-1:0] REG_RD_A,
   output logic [RA-1:0] REG_RD_B,
   output logic          REG_W_EN,
   output logic [RA-1:0] REG_W_ADD,
   output logic          REG_WSEL,
   output logic [1:0]    ALU_OP,
   output logic          FLAG_W,
   output logic          HALTED,
   output logic          ILLEGAL,
   output logic          BUS_ERR,
   output logic [2:0]    STATE
);
   typedef enum logic [2:0] {
      BOOT = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
      MEM  = 3'd4, WB    = 3'd5, HALT   = 3'd6, ERR  = 3'd7
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
   localparam logic [3:0] OP_HALT  = 4'h1;
   localparam logic [3:0] OP_LOAD  = 4'h2;
   localparam logic [3:0] OP_STORE = 4'h3;
   localparam logic [3:0] OP_JMP   = 4'h8;
   localparam logic [3:0] OP_BR    = 4'h9;

   state_t        state, nxt;
   logic [7:0]    wait_cnt;
   logic [3:0]    op;
   logic [1:0]    cond;
   logic [RA-1:0] dest, src;
   logic          timed_out, taken;

   assign op        = INST_Q[IW-1:IW-4];
   assign cond      = INST_Q[IW-5:IW-6];
   assign dest      = INST_Q[2*RA-1:RA];
   assign src       = INST_Q[RA-1:0];
   // Last permitted wait cycle; an ack arriving here still wins.
   assign timed_out = (wait_cnt == WAIT_LAST);

   always_comb begin
      case (cond)
         2'b00:   taken = ~ZF;
         2'b01:   taken = ZF;
         2'b10:   taken = ~ZF & (NF == OF);
         default: taken = (NF == OF);
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= BOOT;
         INST_Q   <= '0;
         wait_cnt <= '0;
      end else begin
         state <= nxt;
         if (state == FETCH && IMEM_ACK) INST_Q <= IMEM_RDATA;
         if (nxt != state)                      wait_cnt <= '0;
         else if (state == FETCH || state == MEM) wait_cnt <= wait_cnt + 8'd1;
      end
   end

   always_comb begin
      nxt = state;
      case (state)
         BOOT:   nxt = FETCH;
         FETCH:  if (IMEM_ACK) nxt = DECODE; else if (timed_out) nxt = ERR;
         DECODE: if (op == OP_LOAD || op == OP_STORE) nxt = MEM;
                 else if (op == OP_HALT)               nxt = HALT;
                 else                                  nxt = EXEC;
         EXEC:   nxt = FETCH;
         MEM:    if (DMEM_ACK) nxt = (op == OP_STORE) ? FETCH : WB;
                 else if (timed_out) nxt = ERR;
         WB:     nxt = FETCH;
         default: nxt = state;
      endcase
   end

   always_comb begin
      IMEM_REQ  = 1'b0;
      DMEM_REQ  = 1'b0;
      DMEM_W_EN = 1'b0;
      PC_EN     = (state == FETCH) && IMEM_ACK;
      PC_LD_EN  = 1'b0;
      REG_RD_A  = '0;
      REG_RD_B  = '0;
      REG_W_EN  = 1'b0;
      REG_W_ADD = '0;
      REG_WSEL  = 1'b0;
      ALU_OP    = 2'b00;
      FLAG_W    = 1'b0;
      HALTED    = 1'b0;
      ILLEGAL   = 1'b0;
      BUS_ERR   = 1'b0;
      STATE     = state;
      if (state == DECODE || state == EXEC || state == MEM || state == WB) begin
         REG_RD_A = dest;
         REG_RD_B = src;
      end
      case (state)
         FETCH: IMEM_REQ = 1'b1;
         EXEC: begin
            case (op)
               4'h4, 4'h5, 4'h6, 4'h7: begin
                  ALU_OP    = op[1:0];
                  FLAG_W    = 1'b1;
                  REG_W_EN  = 1'b1;
                  REG_W_ADD = dest;
               end
               OP_JMP:  PC_LD_EN = 1'b1;
               OP_BR:   PC_LD_EN = taken;
               default: ILLEGAL  = (op >= 4'hA);
            endcase
         end
         MEM: begin
            DMEM_REQ  = 1'b1;
            DMEM_W_EN = (op == OP_STORE);
         end
         WB: begin
            REG_W_EN  = 1'b1;
            REG_W_ADD = dest;
            REG_WSEL  = 1'b1;
         end
         HALT:    HALTED  = 1'b1;
         ERR:     BUS_ERR = 1'b1;
         default: ;
      endcase
   end
endmodule
